// File: rtl/noc_pkg.sv
// Shared mesh NoC types: router port ids, packet-parse states and default link widths.
package noc_pkg;

    localparam int DEFAULT_FLIT_WIDTH = 32;
    localparam int DEFAULT_SIZE_WIDTH = 16;

    typedef enum logic [2:0] {
        EAST  = 3'd0,
        WEST  = 3'd1,
        NORTH = 3'd2,
        SOUTH = 3'd3,
        LOCAL = 3'd4
    } e_port;

    typedef enum logic [1:0] {
        HEADER,
        SIZE,
        PAYLOAD
    } e_pkt_state;

endpackage

// File: rtl/noc_link_fifo.sv
// Circular flit FIFO, DEPTH a power of two; head visible the cycle after push, no bypass.
// Pushes while full and pops while empty are dropped without touching state.
module noc_link_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic             do_push;
    logic             do_pop;

    assign full    = (occ == FULL_OCC);
    assign empty   = (occ == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign head      = mem[rd_ptr];
    assign occupancy = occ;

    // Storage carries no reset; consumers qualify head with empty.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/noc_link_stage.sv
// Credit-flow-controlled retiming buffer for one mesh link direction, with packet-aware counters.
// Latency >= 1 cycle; credit_o drops while full and a same-cycle pop does not re-open it.
module noc_link_stage
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH = DEFAULT_FLIT_WIDTH,
    parameter int DEPTH      = 4,
    parameter int SIZE_WIDTH = DEFAULT_SIZE_WIDTH,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [FLIT_WIDTH-1:0] data_i,
    input  logic                  rx_i,
    output logic                  credit_o,
    output logic [FLIT_WIDTH-1:0] data_o,
    output logic                  tx_o,
    input  logic                  credit_i,
    input  logic                  clear_i,
    output logic [CNT_WIDTH-1:0]  flit_count_o,
    output logic [CNT_WIDTH-1:0]  pkt_count_o,
    output logic [CNT_WIDTH-1:0]  stall_count_o,
    output logic                  in_packet_o
);
    logic [FLIT_WIDTH-1:0]     head;
    logic [$clog2(DEPTH):0]    occupancy;
    logic                      full;
    logic                      empty;
    logic                      push;
    logic                      pop;

    e_pkt_state                state, state_nxt;
    logic [SIZE_WIDTH-1:0]     remaining, remaining_nxt;
    logic                      pkt_done;

    logic [CNT_WIDTH-1:0]      flit_count;
    logic [CNT_WIDTH-1:0]      pkt_count;
    logic [CNT_WIDTH-1:0]      stall_count;

    assign credit_o = ~full;
    assign tx_o     = (occupancy != '0);
    assign data_o   = empty ? '0 : head;
    assign push     = rx_i & credit_o;
    assign pop      = tx_o & credit_i;

    noc_link_fifo #(
        .WIDTH (FLIT_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .din       (data_i),
        .pop       (pop),
        .head      (head),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= HEADER;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
        end
    end

    // Parser moves only on delivered flits, so backpressure never skews packet boundaries.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        pkt_done      = 1'b0;
        if (pop) begin
            case (state)
                HEADER: state_nxt = SIZE;
                SIZE: begin
                    remaining_nxt = data_o[SIZE_WIDTH-1:0];
                    if (data_o[SIZE_WIDTH-1:0] == '0) begin
                        state_nxt = HEADER;
                        pkt_done  = 1'b1;
                    end else begin
                        state_nxt = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    remaining_nxt = remaining - SIZE_WIDTH'(1);
                    if (remaining == SIZE_WIDTH'(1)) begin
                        state_nxt = HEADER;
                        pkt_done  = 1'b1;
                    end
                end
                default: state_nxt = HEADER;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flit_count  <= '0;
            pkt_count   <= '0;
            stall_count <= '0;
        end else if (clear_i) begin
            flit_count  <= '0;
            pkt_count   <= '0;
            stall_count <= '0;
        end else begin
            if (pop) begin
                flit_count <= flit_count + CNT_WIDTH'(1);
            end
            if (pkt_done) begin
                pkt_count <= pkt_count + CNT_WIDTH'(1);
            end
            if (tx_o && !credit_i) begin
                stall_count <= stall_count + CNT_WIDTH'(1);
            end
        end
    end

    assign flit_count_o  = flit_count;
    assign pkt_count_o   = pkt_count;
    assign stall_count_o = stall_count;
    assign in_packet_o   = (state != HEADER);

endmodule

// File: tb/tb_noc_link_stage.sv
// Bench for noc_link_stage: flit scoreboard monitor plus directed counter/FSM checks.
module tb_noc_link_stage;
    localparam int FW    = 32;
    localparam int DEPTH = 4;
    localparam int SW    = 16;
    localparam int CW    = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [FW-1:0] data_i = '0;
    logic          rx_i = 1'b0;
    logic          credit_o;
    logic [FW-1:0] data_o;
    logic          tx_o;
    logic          credit_i = 1'b0;
    logic          clear_i = 1'b0;
    logic [CW-1:0] flit_count_o;
    logic [CW-1:0] pkt_count_o;
    logic [CW-1:0] stall_count_o;
    logic          in_packet_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [FW-1:0] exp_q[$];
    int            m_occ = 0;

    noc_link_stage #(
        .FLIT_WIDTH (FW),
        .DEPTH      (DEPTH),
        .SIZE_WIDTH (SW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .data_i        (data_i),
        .rx_i          (rx_i),
        .credit_o      (credit_o),
        .data_o        (data_o),
        .tx_o          (tx_o),
        .credit_i      (credit_i),
        .clear_i       (clear_i),
        .flit_count_o  (flit_count_o),
        .pkt_count_o   (pkt_count_o),
        .stall_count_o (stall_count_o),
        .in_packet_o   (in_packet_o)
    );

    always #5 clock = ~clock;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference occupancy and flit order; inputs are stable from negedge to the next posedge.
    always @(negedge clock) begin
        bit mpush, mpop;
        logic [FW-1:0] exp;
        if (reset) begin
            exp_q.delete();
            m_occ = 0;
        end else begin
            check("credit_o", {31'd0, credit_o}, {31'd0, m_occ != DEPTH});
            check("tx_o", {31'd0, tx_o}, {31'd0, m_occ != 0});
            mpop  = credit_i && (m_occ != 0);
            mpush = rx_i && (m_occ != DEPTH);
            if (mpop) begin
                exp = exp_q.pop_front();
                check("data_o", data_o, exp);
            end else if (m_occ == 0) begin
                check("data_o_idle", data_o, 32'd0);
            end
            if (mpush) exp_q.push_back(data_i);
            m_occ = m_occ + int'(mpush) - int'(mpop);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rx_i = 1'b0; credit_i = 1'b0; clear_i = 1'b0; data_i = '0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic send(input logic [FW-1:0] d);
        rx_i = 1'b1;
        data_i = d;
        cyc();
    endtask

    task automatic check_counts(string tag, int f, int p, int s);
        check({tag, "_flit"}, 32'(flit_count_o), 32'(f));
        check({tag, "_pkt"}, 32'(pkt_count_o), 32'(p));
        check({tag, "_stall"}, 32'(stall_count_o), 32'(s));
    endtask

    initial begin
        // Reset and idle
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        check("rst_credit", {31'd0, credit_o}, 32'd1);
        check("rst_tx", {31'd0, tx_o}, 32'd0);
        check("rst_data", data_o, 32'd0);
        check("rst_inpkt", {31'd0, in_packet_o}, 32'd0);
        check_counts("rst", 0, 0, 0);

        // Latency / basic packet
        credit_i = 1'b1;
        send(32'h0000_0102);
        check("lat_inpkt0", {31'd0, in_packet_o}, 32'd0);
        send(32'h0000_0002);
        check("lat_inpkt1", {31'd0, in_packet_o}, 32'd1);
        send(32'h0000_000A);
        send(32'h0000_000B);
        check("lat_inpkt_payload", {31'd0, in_packet_o}, 32'd1);
        check("lat_pkt_before", 32'(pkt_count_o), 32'd0);
        rx_i = 1'b0;
        cyc();
        check("lat_inpkt_end", {31'd0, in_packet_o}, 32'd0);
        check_counts("lat", 4, 1, 0);

        // Backpressure
        do_reset();
        send(32'h11);
        send(32'h2);
        send(32'h33);
        check("bp_credit3", {31'd0, credit_o}, 32'd1);
        send(32'h44);
        check("bp_credit4", {31'd0, credit_o}, 32'd0);
        send(32'h55);
        rx_i = 1'b0;
        cyc();
        check_counts("bp_held", 0, 0, 5);
        credit_i = 1'b1;
        repeat (4) cyc();
        check("bp_drained_tx", {31'd0, tx_o}, 32'd0);
        check_counts("bp_drained", 4, 1, 5);

        // Full with simultaneous pop
        do_reset();
        send(32'h1);
        send(32'h3);
        send(32'h66);
        send(32'h77);
        check("full_credit", {31'd0, credit_o}, 32'd0);
        credit_i = 1'b1;
        send(32'hDEAD);
        check("full_pop_credit", {31'd0, credit_o}, 32'd1);
        send(32'hBEEF);
        check("full_both_credit", {31'd0, credit_o}, 32'd1);
        check("full_both_tx", {31'd0, tx_o}, 32'd1);
        rx_i = 1'b0;
        repeat (3) cyc();
        check("full_drained_tx", {31'd0, tx_o}, 32'd0);
        check("full_inpkt", {31'd0, in_packet_o}, 32'd0);
        check_counts("full", 5, 1, 3);

        // Zero-size packet
        do_reset();
        credit_i = 1'b1;
        send(32'h7);
        send(32'h0);
        check("zero_inpkt", {31'd0, in_packet_o}, 32'd1);
        check("zero_pkt_before", 32'(pkt_count_o), 32'd0);
        rx_i = 1'b0;
        cyc();
        check("zero_inpkt_end", {31'd0, in_packet_o}, 32'd0);
        check("zero_pkt", 32'(pkt_count_o), 32'd1);

        // Counter wrap and clear priority
        do_reset();
        credit_i = 1'b1;
        for (int i = 0; i < 17; i++) send(32'(i));
        rx_i = 1'b0;
        cyc();
        check("wrap_flit", 32'(flit_count_o), 32'd1);
        send(32'hAB);
        rx_i = 1'b0;
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        check_counts("clear", 0, 0, 0);
        check("clear_tx", {31'd0, tx_o}, 32'd0);

        // Asynchronous reset mid-packet
        do_reset();
        credit_i = 1'b1;
        send(32'h9);
        send(32'h5);
        send(32'hC1);
        send(32'hC2);
        rx_i = 1'b0;
        check("mid_inpkt", {31'd0, in_packet_o}, 32'd1);
        check("mid_flit", 32'(flit_count_o), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("async_credit", {31'd0, credit_o}, 32'd1);
        check("async_tx", {31'd0, tx_o}, 32'd0);
        check("async_data", data_o, 32'd0);
        check("async_inpkt", {31'd0, in_packet_o}, 32'd0);
        check_counts("async", 0, 0, 0);
        cyc();
        reset = 1'b0;
        repeat (3) cyc();
        check("post_rst_tx", {31'd0, tx_o}, 32'd0);
        check("post_rst_flit", 32'(flit_count_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/noc_link_stage.md
Name: noc_link_stage

Overview:
- Registered, credit-flow-controlled buffer for one direction of one mesh link between neighbouring PE routers. Sits on the data/tx/credit wires that the mesh top currently connects directly.
- Adds parametrised depth and width plus packet-aware monitoring: flit, packet and stall counters, and an in-packet indicator.
- Instantiated per link direction when long links need retiming, and used for link statistics.

Parameters:
- FLIT_WIDTH, 32, flit data width (>= SIZE_WIDTH).
- DEPTH, 4, FIFO entries; power of two, >= 2.
- SIZE_WIDTH, 16, low bits of the size flit that hold the payload length.
- CNT_WIDTH, 32, width of each statistics counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- data_i  in  FLIT_WIDTH  flit from the upstream router's data_o.
- rx_i  in  1  upstream flit valid (the upstream tx).
- credit_o  out  1  buffer can accept a flit (to the upstream credit_i).
- data_o  out  FLIT_WIDTH  flit to the downstream router's data_i.
- tx_o  out  1  flit valid to downstream (the downstream rx).
- credit_i  in  1  downstream can accept a flit.
- clear_i  in  1  synchronous clear of the statistics counters only.
- flit_count_o  out  CNT_WIDTH  flits delivered downstream.
- pkt_count_o  out  CNT_WIDTH  complete packets delivered downstream.
- stall_count_o  out  CNT_WIDTH  cycles where tx_o=1 and credit_i=0.
- in_packet_o  out  1  output-side FSM is not in HEADER.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. Reset clears the FIFO (pointers and occupancy to 0), FSM to HEADER, remaining to 0, all counters to 0. Outputs under reset: credit_o=1, tx_o=0, data_o=0, in_packet_o=0, all counts 0. Reset mid-packet discards buffered flits with no further output.
- Push: when rx_i & credit_o.
- Pop: when tx_o & credit_i.
- credit_o = (occupancy != DEPTH), decoded from the registered occupancy. A pop in the same cycle does not re-enable credit; push is blocked when full.
- tx_o = (occupancy != 0). data_o = FIFO head, driven 0 when empty.
- Latency: a flit pushed in cycle t is visible on data_o / tx_o in cycle t+1 at the earliest. There is no bypass.
- Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- rx_i while credit_o=0: flit is ignored. This is a protocol error upstream; the block must not corrupt state.
- Packet FSM advances on pop only. Packet format is header flit, size flit, then size payload flits.
  - HEADER: pop moves to SIZE.
  - SIZE: pop latches remaining = data_o[SIZE_WIDTH-1:0]. If the value is 0, go to HEADER and increment pkt_count; otherwise go to PAYLOAD.
  - PAYLOAD: each pop decrements remaining. The pop taken with remaining==1 goes to HEADER and increments pkt_count.
- flit_count increments on every pop.
- stall_count increments on each cycle with tx_o & ~credit_i.
- Counters wrap modulo 2^CNT_WIDTH.
- clear_i: zeroes all three counters next edge and has priority over a same-cycle increment. FIFO and FSM are unaffected.

Decomposition:
- Shared package noc_pkg holds:
  - e_port enum (EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4), so the mesh top stops redefining it locally;
  - e_pkt_state enum (HEADER, SIZE, PAYLOAD);
  - default FLIT_WIDTH and SIZE_WIDTH constants.
- One sub-module, noc_link_fifo: parametrised circular FIFO exposing push, pop, head, occupancy, full and empty. The FSM and counters stay in noc_link_stage.

Test Plan:
- Reset then idle: credit_o=1, tx_o=0, all counts 0; assert reset mid-stream and confirm every output returns to its reset value immediately.
- Latency: credit_i=1, push header 0x00000102, size 0x00000002, payload 0xA, 0xB on consecutive cycles.
  - Each flit appears on data_o one cycle after its push.
  - pkt_count goes 0→1 on the 0xB pop; flit_count=4; in_packet_o high from the header pop until the 0xB pop.
- Backpressure, DEPTH=4, credit_i=0: push 4 flits.
  - credit_o drops after the 4th push.
  - A 5th rx_i is ignored.
  - stall_count counts each held cycle.
  - Releasing credit_i drains the 4 flits in order.
- Full with simultaneous pop: at occupancy 4 with credit_i=1 and rx_i=1, no push is accepted that cycle and occupancy goes to 3. The next cycle push and pop both occur and occupancy stays 3.
- Zero-size packet: header then size 0x00000000 → pkt_count increments on the size pop and the FSM returns to HEADER.
- Wrap and clear, CNT_WIDTH=4: 17 flits → flit_count=1. Then clear_i in the same cycle as a pop → flit_count=0.
